// File: rtl/synchro_event_bank_if.sv
// Bus bundle between the async-event bank and its consumer (register file / bench).
interface synchro_event_bank_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] asyncIn;
   logic             clearStrobe;
   logic [WIDTH-1:0] clearMask;
   logic [WIDTH-1:0] irqEnable;
   logic [WIDTH-1:0] syncOut;
   logic [WIDTH-1:0] risePulse;
   logic [WIDTH-1:0] fallPulse;
   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] overflow;
   logic             irq;

   // Consumer side: drives inputs and clear/enable, observes status.
   modport master (
      output asyncIn, clearStrobe, clearMask, irqEnable,
      input  syncOut, risePulse, fallPulse, pending, overflow, irq
   );

   // Event bank side.
   modport slave (
      input  asyncIn, clearStrobe, clearMask, irqEnable,
      output syncOut, risePulse, fallPulse, pending, overflow, irq
   );
endinterface

// File: rtl/synchro_event_bank.sv
// Multi-channel async input synchroniser with glitch filter, edge detect,
// sticky pending/overflow flags and an aggregated registered interrupt.
module synchro_event_bank #(
   parameter int unsigned     WIDTH      = 8,
   parameter int unsigned     STAGES     = 2,
   parameter int unsigned     FILTER     = 4,
   parameter logic [WIDTH-1:0] RISE_MASK = '1,
   parameter logic [WIDTH-1:0] FALL_MASK = '0,
   parameter logic [WIDTH-1:0] INIT_LEVEL = '0
) (
   input logic                  clock,
   input logic                  nReset,
   synchro_event_bank_if.slave  bus
);

   localparam int unsigned      CNT_W    = $clog2(FILTER + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] sync_d [STAGES];
   logic [CNT_W-1:0] cnt_q  [WIDTH];
   logic [CNT_W-1:0] cnt_d  [WIDTH];
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] ovf_q, ovf_d;
   logic             irq_q, irq_d;

   logic [WIDTH-1:0] sync_val_c;
   logic [WIDTH-1:0] event_c;
   logic [WIDTH-1:0] clr_c;

   assign sync_val_c = sync_q[STAGES-1];
   assign event_c    = (rise_q & RISE_MASK) | (fall_q & FALL_MASK);
   assign clr_c      = bus.clearStrobe ? bus.clearMask : '0;

   // Synchroniser chain shift.
   always_comb begin
      sync_d[0] = bus.asyncIn;
      for (int unsigned k = 1; k < STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   // Stability filter: a new level must persist FILTER cycles; edges pulse on acceptance.
   always_comb begin
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_val_c[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]   = '0;
            level_d[i] = sync_val_c[i];
            rise_d[i]  = sync_val_c[i];
            fall_d[i]  = ~sync_val_c[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Sticky pending/overflow: a simultaneous event wins over clear but resets overflow.
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (event_c[i]) begin
            pend_d[i] = 1'b1;
            if (clr_c[i]) begin
               ovf_d[i] = 1'b0;
            end else if (pend_q[i]) begin
               ovf_d[i] = 1'b1;
            end
         end else if (clr_c[i]) begin
            pend_d[i] = 1'b0;
            ovf_d[i]  = 1'b0;
         end
      end
   end

   // Interrupt aggregation.
   always_comb begin
      irq_d = |(pend_q & bus.irqEnable);
   end

   // Synchroniser flops.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            sync_q[k] <= INIT_LEVEL;
         end
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            sync_q[k] <= sync_d[k];
         end
      end
   end

   // Filter counters, accepted level and edge pulses.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         level_q <= INIT_LEVEL;
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Status flags and interrupt.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         pend_q <= '0;
         ovf_q  <= '0;
         irq_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         irq_q  <= irq_d;
      end
   end

   assign bus.syncOut   = level_q;
   assign bus.risePulse = rise_q;
   assign bus.fallPulse = fall_q;
   assign bus.pending   = pend_q;
   assign bus.overflow  = ovf_q;
   assign bus.irq       = irq_q;

endmodule

// File: tb/tb_synchro_event_bank.sv
// Directed bench for synchro_event_bank: per-cycle vector table plus
// hand sequences for overflow, clear collisions, fall events and mid-filter reset.
module tb_synchro_event_bank;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NVEC  = 22;

   logic clock = 1'b0;
   logic nReset;

   always #5 clock = ~clock;

   synchro_event_bank_if #(.WIDTH(WIDTH)) bus ();

   synchro_event_bank #(
      .WIDTH      (WIDTH),
      .STAGES     (2),
      .FILTER     (4),
      .RISE_MASK  (8'hFB),
      .FALL_MASK  (8'h04),
      .INIT_LEVEL (8'h00)
   ) dut (
      .clock  (clock),
      .nReset (nReset),
      .bus    (bus)
   );

   typedef struct {
      logic [7:0] in_v;
      logic [7:0] sync;
      logic [7:0] rise;
      logic [7:0] fall;
      logic [7:0] pend;
      logic [7:0] ovf;
      logic       irq;
   } vec_t;

   vec_t vecs [NVEC];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic [7:0] in_v, input logic [7:0] sync,
                               input logic [7:0] rise, input logic [7:0] fall,
                               input logic [7:0] pend, input logic [7:0] ovf,
                               input logic irq);
      vec_t v;
      v.in_v = in_v; v.sync = sync; v.rise = rise; v.fall = fall;
      v.pend = pend; v.ovf = ovf; v.irq = irq;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] sync, input logic [7:0] rise,
                          input logic [7:0] fall, input logic [7:0] pend,
                          input logic [7:0] ovf, input logic irq);
      chk({tag, ".syncOut"},   32'(bus.syncOut),   32'(sync));
      chk({tag, ".risePulse"}, 32'(bus.risePulse), 32'(rise));
      chk({tag, ".fallPulse"}, 32'(bus.fallPulse), 32'(fall));
      chk({tag, ".pending"},   32'(bus.pending),   32'(pend));
      chk({tag, ".overflow"},  32'(bus.overflow),  32'(ovf));
      chk({tag, ".irq"},       32'(bus.irq),       32'(irq));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic hold(input logic [7:0] v, input int n);
      bus.asyncIn = v;
      repeat (n) step();
   endtask

   initial begin
      // Reset release + rise latency, 3-cycle glitch on ch1, then 4-cycle accept on ch1.
      for (int i = 0; i < 5; i++) vecs[i] = mk(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      vecs[5] = mk(8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
      vecs[6] = mk(8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0);
      vecs[7] = mk(8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1);
      for (int i = 8;  i < 11; i++) vecs[i] = mk(8'h03, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1);
      for (int i = 11; i < 15; i++) vecs[i] = mk(8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1);
      for (int i = 15; i < 20; i++) vecs[i] = mk(8'h03, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1);
      vecs[20] = mk(8'h03, 8'h03, 8'h02, 8'h00, 8'h01, 8'h00, 1'b1);
      vecs[21] = mk(8'h03, 8'h03, 8'h00, 8'h00, 8'h03, 8'h00, 1'b1);

      nReset          = 1'b0;
      bus.asyncIn     = 8'h01;
      bus.clearStrobe = 1'b0;
      bus.clearMask   = 8'h00;
      bus.irqEnable   = 8'h01;
      repeat (3) step();
      chk_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      nReset = 1'b1;

      for (int i = 0; i < int'(NVEC); i++) begin
         bus.asyncIn = vecs[i].in_v;
         step();
         chk_all($sformatf("v%0d", i + 1), vecs[i].sync, vecs[i].rise, vecs[i].fall,
                 vecs[i].pend, vecs[i].ovf, vecs[i].irq);
      end

      // Second rising edge on ch0 while pending -> overflow.
      hold(8'h02, 6);
      chk_all("fall0", 8'h02, 8'h00, 8'h01, 8'h03, 8'h00, 1'b1);
      hold(8'h03, 6);
      chk_all("rise0b", 8'h03, 8'h01, 8'h00, 8'h03, 8'h00, 1'b1);
      step();
      chk_all("ovf0", 8'h03, 8'h00, 8'h00, 8'h03, 8'h01, 1'b1);

      // Clear on the same cycle as a ch0 rise pulse: pending held, overflow cleared.
      hold(8'h02, 6);
      hold(8'h03, 6);
      chk("rise0c.risePulse", 32'(bus.risePulse), 32'h01);
      bus.clearStrobe = 1'b1;
      bus.clearMask   = 8'h01;
      step();
      bus.clearStrobe = 1'b0;
      bus.clearMask   = 8'hFF;
      chk_all("clr_evt", 8'h03, 8'h00, 8'h00, 8'h03, 8'h00, 1'b1);

      // clearMask is ignored without clearStrobe.
      step();
      chk("mask_no_strobe.pending", 32'(bus.pending), 32'h03);

      // Plain clear of ch0; irq drops a cycle later.
      bus.clearStrobe = 1'b1;
      bus.clearMask   = 8'h01;
      step();
      bus.clearStrobe = 1'b0;
      bus.clearMask   = 8'h00;
      chk_all("clr0", 8'h03, 8'h00, 8'h00, 8'h02, 8'h00, 1'b1);
      step();
      chk("clr0_irq", 32'(bus.irq), 32'h0);

      // Enabling an already pending channel raises irq next edge.
      bus.irqEnable = 8'h02;
      step();
      chk("en1_irq", 32'(bus.irq), 32'h1);
      bus.irqEnable = 8'h00;
      step();
      chk("dis_irq", 32'(bus.irq), 32'h0);

      // Channel 2: rise not masked for events, fall is.
      hold(8'h07, 6);
      chk_all("rise2", 8'h07, 8'h04, 8'h00, 8'h02, 8'h00, 1'b0);
      step();
      chk_all("rise2_nopend", 8'h07, 8'h00, 8'h00, 8'h02, 8'h00, 1'b0);
      hold(8'h03, 6);
      chk_all("fall2", 8'h03, 8'h00, 8'h04, 8'h02, 8'h00, 1'b0);
      step();
      chk_all("fall2_pend", 8'h03, 8'h00, 8'h00, 8'h06, 8'h00, 1'b0);

      // Reset mid-filter (ch3 counter at 2), then full latency after release.
      hold(8'h0B, 4);
      nReset = 1'b0;
      #1;
      chk_all("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      repeat (2) step();
      nReset = 1'b1;
      hold(8'h0B, 5);
      chk_all("post_rst5", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      step();
      chk_all("post_rst6", 8'h0B, 8'h0B, 8'h00, 8'h00, 8'h00, 1'b0);
      step();
      chk_all("post_rst7", 8'h0B, 8'h00, 8'h00, 8'h0B, 8'h00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/synchro_event_bank.md
Name: synchro_event_bank

Overview:
- Multi-channel successor to the single-bit synchroniser flop.
- Brings WIDTH asynchronous level inputs into one clock domain through a parameterised synchroniser chain.
- Each channel then passes a stability (glitch) filter and edge detection, and sets a sticky pending/overflow flag.
- Drives an aggregated interrupt request; sits between board-level async signals (buttons, external strobes) and the peripheral register file.

Parameters:
- WIDTH, 8, number of independent channels (1..32).
- STAGES, 2, synchroniser flops per channel (2..4).
- FILTER, 4, consecutive cycles the synchronised value must differ from the filtered level before it is accepted (1..255; 1 = no filtering).
- RISE_MASK, all ones, bit i=1: rising edges on channel i raise events.
- FALL_MASK, all zeros, bit i=1: falling edges on channel i raise events.
- INIT_LEVEL, all zeros, reset value of the sync chain and filtered level per channel.

Ports:
- clock  in  1  single clock; all flops rising-edge.
- nReset  in  1  asynchronous, active-low reset.
- asyncIn  in  WIDTH  asynchronous level inputs.
- clearStrobe  in  1  one-cycle clear request.
- clearMask  in  WIDTH  channels cleared when clearStrobe=1.
- irqEnable  in  WIDTH  per-channel interrupt enable.
- syncOut  out  WIDTH  filtered, synchronised level.
- risePulse  out  WIDTH  one-cycle pulse on filtered 0->1.
- fallPulse  out  WIDTH  one-cycle pulse on filtered 1->0.
- pending  out  WIDTH  sticky event flags.
- overflow  out  WIDTH  sticky flag: event while already pending.
- irq  out  1  registered OR of pending & irqEnable.

Behaviour:
- Reset (nReset=0, async): sync chains and syncOut = INIT_LEVEL; filter counters, risePulse, fallPulse, pending, overflow and irq = 0. Takes effect immediately, including mid-filter; no pulses are generated on release.
- Sync chain: s[0] <= asyncIn; s[k] <= s[k-1]; the synchronised value is s[STAGES-1].
- Filter, per channel, counter width ceil(log2(FILTER+1)):
  - If the synchronised value equals syncOut: counter <= 0.
  - Else if counter == FILTER-1: syncOut <= synchronised value, counter <= 0.
  - Else: counter++.
  - Any reversion before acceptance clears the counter; a glitch shorter than FILTER cycles never reaches syncOut.
- Latency: with asyncIn stable, syncOut changes on rising edge STAGES+FILTER, counting the edge that first samples the new value as edge 1.
- Pulses: risePulse[i]/fallPulse[i] are registered and high exactly during the first cycle syncOut[i] shows the new value. Never both high; never high on consecutive cycles for the same direction.
- Event: event[i] = (risePulse[i] & RISE_MASK[i]) | (fallPulse[i] & FALL_MASK[i]).
- Pending and overflow, per channel, evaluated each cycle:
  - clr = clearStrobe & clearMask[i].
  - event & ~pending: pending <= 1.
  - event & pending & ~clr: overflow <= 1.
  - event & clr: pending stays 1 (set wins), overflow <= 0.
  - clr & ~event: pending <= 0, overflow <= 0.
  - clearStrobe=0: clearMask ignored.
- irq <= |(pending & irqEnable); one cycle after pending/enable changes. Enabling a channel that is already pending raises irq on the next edge.
- No combinational paths from inputs to outputs.

Test Plan:
- Reset release, STAGES=2, FILTER=4, asyncIn held 0x01: syncOut[0]=1 after edge 6, risePulse[0]=1 that cycle only, pending=0x01, irq=1 one cycle later (irqEnable=0x01).
- 3-cycle high glitch on asyncIn[1] (FILTER=4) -> syncOut, pulses and pending unchanged; a 4-cycle-stable high is accepted.
- Two separate accepted rising edges on channel 0 without clear -> pending[0]=1, overflow[0]=1; then clearStrobe with clearMask=0x01 -> both 0 next cycle, irq drops one cycle after that.
- clearStrobe with clearMask=0x01 on the same cycle as risePulse[0] -> pending[0] stays 1, overflow[0]=0.
- FALL_MASK bit 2 set, RISE_MASK bit 2 clear: channel 2 1->0 -> fallPulse[2] and pending[2]; 0->1 -> risePulse[2] only, no pending.
- nReset asserted mid-filter (counter=2) -> all outputs at reset values immediately; after release a stable input needs a full STAGES+FILTER edges.
